// File: rtl/odd_even_split_buffer.sv
// Double-buffered odd/even deinterleaver for the merge stage.
// Two sorted sequences stream in serially; split halves leave in parallel.
module odd_even_split_buffer #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_odd,
  output logic [N*WIDTH-1:0] out_even,
  output logic               frame_err
);

  localparam int CW = $clog2(2 * N);
  localparam int SW = CW - 1;

  logic [CW-1:0]      cnt;
  logic [1:0]         full;
  logic [1:0]         fullNext;
  logic               wb;
  logic               rb;
  logic               errQ;
  logic [N*WIDTH-1:0] oddBank  [2];
  logic [N*WIDTH-1:0] evenBank [2];

  logic               accept;
  logic               pop;
  logic               atEnd;
  logic               closeOk;
  logic               lenErr;
  logic [SW-1:0]      slot;

  assign in_ready  = !full[wb] && !clr;
  assign out_valid = full[rb];
  assign out_odd   = oddBank[rb];
  assign out_even  = evenBank[rb];
  assign frame_err = errQ;

  // Handshake decode; N is even, so slot s*(N/2)+p/2 is simply cnt/2
  always_comb begin
    accept   = in_valid && in_ready;
    pop      = full[rb] && out_ready && !clr;
    atEnd    = (cnt == CW'(2 * N - 1));
    closeOk  = accept && in_last && atEnd;
    lenErr   = accept && (in_last != atEnd);
    slot     = cnt[CW-1:1];
    fullNext = full;
    if (closeOk) fullNext[wb] = 1'b1;
    if (pop)     fullNext[rb] = 1'b0;
  end

  // Frame counter, bank pointers, full flags and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      full <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      errQ <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      full <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      errQ <= 1'b0;
    end else begin
      errQ <= lenErr;
      full <= fullNext;
      if (accept) begin
        if (closeOk || lenErr) cnt <= '0;
        else                   cnt <= cnt + 1'b1;
      end
      if (closeOk) wb <= ~wb;
      if (pop)     rb <= ~rb;
    end
  end

  // Route each accepted element into its odd or even slot of the write bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oddBank[0]  <= '0;
      oddBank[1]  <= '0;
      evenBank[0] <= '0;
      evenBank[1] <= '0;
    end else if (accept) begin
      if (cnt[0])
        evenBank[wb][int'(slot)*WIDTH +: WIDTH] <= in_data;
      else
        oddBank[wb][int'(slot)*WIDTH +: WIDTH] <= in_data;
    end
  end

endmodule
